// File: rtl/final_round_dec_out.sv
// final_round_dec_out
//   Last stage of the AES-128 inverse cipher: undoes round 1 and applies the
//   cipher key, then buffers plaintext blocks in a 2-entry output FIFO with
//   valid/ready handshake.
//
//   Stage 1 (registered): s1 = InvSubBytes(InvShiftRows(InvMixColumns(IN ^ KEY1)))
//   Stage 2 (comb)      : ptxt = s1 ^ k0_q, pushed into the FIFO when s1_valid
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   in_valid   in   IN/KEY1/KEY0 carry a block this cycle
//   IN         in   state from the earlier decryption rounds
//   KEY1       in   round key 1
//   KEY0       in   round key 0 (cipher key)
//   out_ready  in   consumer accepts OUT this cycle
//   out_valid  out  OUT holds a valid plaintext block
//   OUT        out  plaintext block (holds the last head value when empty)
//   overflow   out  sticky: a block was dropped because the FIFO was full
//   drop_cnt   out  (only with AES_DEC_DROP_CNT_EN) saturating drop count
//
// Configuration macro: AES_DEC_DROP_CNT_EN adds the drop_cnt output.
// The transforms are the AES byte transforms and assume BLOCK_LENGTH = 128.

module final_round_dec_out #(
  parameter int BLOCK_LENGTH = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [BLOCK_LENGTH-1:0] IN,
  input  logic [BLOCK_LENGTH-1:0] KEY1,
  input  logic [BLOCK_LENGTH-1:0] KEY0,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [BLOCK_LENGTH-1:0] OUT,
  output logic                    overflow
`ifdef AES_DEC_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  // Inverse S-box, byte x lives at bits [8*(255-x)+7 -: 8].
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  // ---------------------------------------------------------------------------
  // Transform blocks. State byte i (i = row + 4*col) sits at bits
  // [BLOCK_LENGTH-1-8*i -: 8], i.e. the first byte of the block is the MSB.
  // ---------------------------------------------------------------------------
  function automatic logic [BLOCK_LENGTH-1:0] key_add(
    input logic [BLOCK_LENGTH-1:0] s,
    input logic [BLOCK_LENGTH-1:0] k
  );
    return s ^ k;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] inv_mix_columns(
    input logic [BLOCK_LENGTH-1:0] s
  );
    logic [BLOCK_LENGTH-1:0] r;
    logic [7:0] a [4];
    logic [7:0] x2 [4];
    logic [7:0] x4 [4];
    logic [7:0] x8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int j = 0; j < 4; j++) begin
        a[j]  = s[BLOCK_LENGTH-1-8*(4*c+j) -: 8];
        x2[j] = xtime(a[j]);
        x4[j] = xtime(x2[j]);
        x8[j] = xtime(x4[j]);
        m9[j] = x8[j] ^ a[j];
        mb[j] = x8[j] ^ x2[j] ^ a[j];
        md[j] = x8[j] ^ x4[j] ^ a[j];
        me[j] = x8[j] ^ x4[j] ^ x2[j];
      end
      r[BLOCK_LENGTH-1-8*(4*c+0) -: 8] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
      r[BLOCK_LENGTH-1-8*(4*c+1) -: 8] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
      r[BLOCK_LENGTH-1-8*(4*c+2) -: 8] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
      r[BLOCK_LENGTH-1-8*(4*c+3) -: 8] = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    end
    return r;
  endfunction

  // Row r rotates right by r columns.
  function automatic logic [BLOCK_LENGTH-1:0] inv_shift_rows(
    input logic [BLOCK_LENGTH-1:0] s
  );
    logic [BLOCK_LENGTH-1:0] r;
    r = '0;
    for (int row = 0; row < 4; row++) begin
      for (int c = 0; c < 4; c++) begin
        r[BLOCK_LENGTH-1-8*(row+4*((c+row)%4)) -: 8] = s[BLOCK_LENGTH-1-8*(row+4*c) -: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [BLOCK_LENGTH-1:0] inv_sub_bytes(
    input logic [BLOCK_LENGTH-1:0] s
  );
    logic [BLOCK_LENGTH-1:0] r;
    logic [7:0] b;
    r = '0;
    for (int i = 0; i < BLOCK_LENGTH/8; i++) begin
      b = s[BLOCK_LENGTH-1-8*i -: 8];
      r[BLOCK_LENGTH-1-8*i -: 8] = INV_SBOX[{~b, 3'b111} -: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1
  // ---------------------------------------------------------------------------
  logic [BLOCK_LENGTH-1:0] s1_d;
  logic [BLOCK_LENGTH-1:0] s1;
  logic [BLOCK_LENGTH-1:0] k0_q;
  logic                    s1_valid;
  // Low until the first edge after reset release, so a block sitting on the
  // inputs while reset is let go is never captured.
  logic                    armed;

  always_comb begin
    s1_d = inv_sub_bytes(inv_shift_rows(inv_mix_columns(key_add(IN, KEY1))));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1       <= '0;
      k0_q     <= '0;
      s1_valid <= 1'b0;
      armed    <= 1'b0;
    end else begin
      armed    <= 1'b1;
      s1       <= s1_d;
      k0_q     <= KEY0;
      s1_valid <= in_valid && armed;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: key 0 add and 2-entry output FIFO
  // ---------------------------------------------------------------------------
  logic [BLOCK_LENGTH-1:0] ptxt;
  logic [BLOCK_LENGTH-1:0] mem0, mem1;
  logic [BLOCK_LENGTH-1:0] mem0_next, mem1_next;
  logic [BLOCK_LENGTH-1:0] head_next;
  logic [BLOCK_LENGTH-1:0] out_q;
  logic                    wr_ptr, rd_ptr;
  logic                    wr_next, rd_next;
  logic [1:0]              count, count_next;
  logic                    full, push, pop, drop;
  logic                    overflow_q;

  always_comb begin
    ptxt       = key_add(s1, k0_q);
    full       = (count == 2'd2);
    pop        = (count != 2'd0) && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push       = s1_valid && (!full || pop);
    drop       = s1_valid && full && !pop;
    wr_next    = wr_ptr ^ push;
    rd_next    = rd_ptr ^ pop;
    count_next = count + {1'b0, push} - {1'b0, pop};
    mem0_next  = (push && !wr_ptr) ? ptxt : mem0;
    mem1_next  = (push &&  wr_ptr) ? ptxt : mem1;
    head_next  = rd_next ? mem1_next : mem0_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem0       <= '0;
      mem1       <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      count      <= 2'd0;
      out_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      mem0   <= mem0_next;
      mem1   <= mem1_next;
      wr_ptr <= wr_next;
      rd_ptr <= rd_next;
      count  <= count_next;
      // OUT is a register so it keeps the last head once the FIFO drains.
      if (count_next != 2'd0) begin
        out_q <= head_next;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign out_valid = (count != 2'd0);
  assign OUT       = out_q;
  assign overflow  = overflow_q;

`ifdef AES_DEC_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 8'd0;
    end else if (drop && (drop_cnt_q != 8'hff)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule
